// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro used by instr_fetch: IFETCH_MISALIGN_TRAP_EN.
package ifetch_pkg;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous {pc, instr} buffer with flush; the head output holds the last
// presented entry while empty so decode never sees a combinational glitch.
module fetch_fifo
   import ifetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [CW-1:0] count,
   output logic         full,
   output logic         empty
);

   fetch_entry_t   mem_q [DEPTH];
   fetch_entry_t   mem_d [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   fetch_entry_t   hold_q, hold_d;
   logic           push_eff;
   logic           pop_eff;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign head  = empty ? hold_q : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      hold_d   = head;
      pop_eff  = pop && !empty;
      push_eff = push && (!full || pop_eff);

      // Flush wins over a same-cycle push or pop: both belong to the old stream.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_eff) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hold_q   <= hold_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues fixed-latency IMEM reads and buffers them.
// Define IFETCH_MISALIGN_TRAP_EN to trap (halt) on misaligned redirect targets.
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic [31:0] IMemRdata,
   output logic        InstrValid,
   output logic [31:0] InstrOut,
   output logic [31:0] PcOut,
   input  logic        DecReady,
`ifdef IFETCH_MISALIGN_TRAP_EN
   output logic        FetchMisalign,
`endif
   input  logic        Redirect,
   input  logic [31:0] RedirectPc
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   pc_q, pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic          drop_q, drop_d;
   logic [31:0]   redirect_target;
   logic          halt;
   logic          issue;
   logic          pop;
   logic          push;
   logic [CW:0]   occupancy;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   assign redirect_target = RedirectPc;
   assign halt            = misalign_q;
   assign FetchMisalign   = misalign_q;

   always_comb begin
      misalign_d = misalign_q;
      if (Redirect) begin
         misalign_d = |RedirectPc[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) misalign_q <= 1'b0;
      else       misalign_q <= misalign_d;
   end
`else
   assign redirect_target = RedirectPc & ~32'h0000_0003;
   assign halt            = 1'b0;
`endif

   assign InstrValid = !fifo_empty;
   assign InstrOut   = head.instr;
   assign PcOut      = head.pc;
   assign pop        = InstrValid && DecReady;

   // Entries already committed (buffered + in flight) minus the one leaving now.
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
   assign issue     = !reset && !Redirect && !halt &&
                      ((occupancy - {{CW{1'b0}}, pop}) < (CW+1)'(FIFO_DEPTH));
   assign IMemReq   = issue;
   assign IMemAddr  = issue ? pc_q : 32'h0;

   assign push       = inflight_q && !drop_q;
   assign push_entry = '{pc: inflight_pc_q, instr: IMemRdata};

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      drop_d        = 1'b0;
      if (issue) begin
         pc_d          = pc_q + 32'(INSTR_BYTES);
         inflight_pc_d = pc_q;
      end
      if (Redirect) begin
         pc_d   = redirect_target;
         drop_d = inflight_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'h0;
         drop_q        <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         drop_q        <= drop_d;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (Redirect),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Occupancy is bounded by the issue rule, so full is informational here.
   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch with a 1-cycle IMEM model.
module tb_instr_fetch;

   localparam logic [31:0] XORK = 32'hA5A5_0000;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        dec_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        fetch_misalign;
`endif

   int checks;
   int failures;

   instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .IMemReq    (imem_req),
      .IMemAddr   (imem_addr),
      .IMemRdata  (imem_rdata),
      .InstrValid (instr_valid),
      .InstrOut   (instr_out),
      .PcOut      (pc_out),
      .DecReady   (dec_ready),
`ifdef IFETCH_MISALIGN_TRAP_EN
      .FetchMisalign (fetch_misalign),
`endif
      .Redirect   (redirect),
      .RedirectPc (redirect_pc)
   );

   // clock / memory model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial imem_rdata = 32'h0;
   always @(posedge clk) begin
      imem_rdata <= imem_req ? (imem_addr ^ XORK) : 32'hDEAD_BEEF;
   end

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] einstr;
      logic        ereq;
      logic [31:0] eaddr;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic rst, input logic rdy, input logic redir,
                               input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                               input logic [31:0] einstr, input logic ereq, input logic [31:0] eaddr);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
      v.ev = ev; v.epc = epc; v.einstr = einstr; v.ereq = ereq; v.eaddr = eaddr;
      return v;
   endfunction

   task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] target;
      int          lat;
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      dec_ready = 1'b0;
      redirect  = 1'b0;
      redirect_pc = 32'h0;

      //            rst rdy rd  rpc           ev  epc           einstr               req addr
      vecs[0]  = mk(0,  1,  0,  32'h0,        0,  32'h0,        32'h0,               1,  32'h0);
      vecs[1]  = mk(0,  1,  0,  32'h0,        0,  32'h0,        32'h0,               1,  32'h4);
      vecs[2]  = mk(0,  1,  0,  32'h0,        1,  32'h0,        XORK ^ 32'h0,        1,  32'h8);
      vecs[3]  = mk(0,  0,  0,  32'h0,        1,  32'h4,        XORK ^ 32'h4,        0,  32'h0);
      vecs[4]  = mk(0,  0,  0,  32'h0,        1,  32'h4,        XORK ^ 32'h4,        0,  32'h0);
      vecs[5]  = mk(0,  0,  0,  32'h0,        1,  32'h4,        XORK ^ 32'h4,        0,  32'h0);
      vecs[6]  = mk(0,  0,  0,  32'h0,        1,  32'h4,        XORK ^ 32'h4,        0,  32'h0);
      vecs[7]  = mk(0,  0,  0,  32'h0,        1,  32'h4,        XORK ^ 32'h4,        0,  32'h0);
      vecs[8]  = mk(0,  1,  0,  32'h0,        1,  32'h4,        XORK ^ 32'h4,        1,  32'hC);
      vecs[9]  = mk(0,  1,  0,  32'h0,        1,  32'h8,        XORK ^ 32'h8,        1,  32'h10);
      vecs[10] = mk(0,  1,  0,  32'h0,        1,  32'hC,        XORK ^ 32'hC,        1,  32'h14);
      vecs[11] = mk(0,  1,  0,  32'h0,        1,  32'h10,       XORK ^ 32'h10,       1,  32'h18);
      vecs[12] = mk(0,  0,  1,  32'h100,      1,  32'h14,       XORK ^ 32'h14,       0,  32'h0);
      vecs[13] = mk(0,  1,  0,  32'h0,        0,  32'h14,       XORK ^ 32'h14,       1,  32'h100);
      vecs[14] = mk(0,  1,  0,  32'h0,        0,  32'h14,       XORK ^ 32'h14,       1,  32'h104);
      vecs[15] = mk(0,  1,  0,  32'h0,        1,  32'h100,      XORK ^ 32'h100,      1,  32'h108);
      vecs[16] = mk(0,  1,  1,  32'h300,      1,  32'h104,      XORK ^ 32'h104,      0,  32'h0);
      vecs[17] = mk(0,  1,  1,  32'h200,      0,  32'h104,      XORK ^ 32'h104,      0,  32'h0);
      vecs[18] = mk(0,  1,  0,  32'h0,        0,  32'h104,      XORK ^ 32'h104,      1,  32'h200);
      vecs[19] = mk(0,  1,  0,  32'h0,        0,  32'h104,      XORK ^ 32'h104,      1,  32'h204);
      vecs[20] = mk(0,  1,  0,  32'h0,        1,  32'h200,      XORK ^ 32'h200,      1,  32'h208);
      vecs[21] = mk(0,  1,  0,  32'h0,        1,  32'h204,      XORK ^ 32'h204,      1,  32'h20C);
      vecs[22] = mk(1,  1,  0,  32'h0,        1,  32'h208,      XORK ^ 32'h208,      0,  32'h0);
      vecs[23] = mk(0,  1,  0,  32'h0,        0,  32'h0,        32'h0,               1,  32'h0);
      vecs[24] = mk(0,  1,  0,  32'h0,        0,  32'h0,        32'h0,               1,  32'h4);
      vecs[25] = mk(0,  1,  0,  32'h0,        1,  32'h0,        XORK ^ 32'h0,        1,  32'h8);
      vecs[26] = mk(0,  1,  1,  32'hFFFF_FFFC, 1, 32'h4,        XORK ^ 32'h4,        0,  32'h0);
      vecs[27] = mk(0,  1,  0,  32'h0,        0,  32'h4,        XORK ^ 32'h4,        1,  32'hFFFF_FFFC);
      vecs[28] = mk(0,  1,  0,  32'h0,        0,  32'h4,        XORK ^ 32'h4,        1,  32'h0);
      vecs[29] = mk(0,  1,  0,  32'h0,        1,  32'hFFFF_FFFC, XORK ^ 32'hFFFF_FFFC, 1, 32'h4);
      vecs[30] = mk(0,  1,  0,  32'h0,        1,  32'h0,        XORK ^ 32'h0,        1,  32'h8);

      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         reset       = vecs[i].rst;
         dec_ready   = vecs[i].rdy;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         @(negedge clk);
         chk("instr_valid", i, {31'h0, instr_valid}, {31'h0, vecs[i].ev});
         chk("pc_out",      i, pc_out,               vecs[i].epc);
         chk("instr_out",   i, instr_out,            vecs[i].einstr);
         chk("imem_req",    i, {31'h0, imem_req},    {31'h0, vecs[i].ereq});
         chk("imem_addr",   i, imem_addr,            vecs[i].eaddr);
         next_cycle();
      end

      // misaligned redirect target
      reset       = 1'b0;
      dec_ready   = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0102;
      @(negedge clk);
      chk("misalign_redir_req", 100, {31'h0, imem_req}, 32'h0);
      next_cycle();
      redirect = 1'b0;
      @(negedge clk);
`ifdef IFETCH_MISALIGN_TRAP_EN
      chk("misalign_flag", 101, {31'h0, fetch_misalign}, 32'h1);
      chk("misalign_halt", 101, {31'h0, imem_req}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         @(negedge clk);
         chk("misalign_halt_hold", 102 + k, {31'h0, imem_req}, 32'h0);
         chk("misalign_no_valid",  102 + k, {31'h0, instr_valid}, 32'h0);
      end
      next_cycle();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0104;
      @(negedge clk);
      chk("misalign_fix_req", 105, {31'h0, imem_req}, 32'h0);
      next_cycle();
      redirect = 1'b0;
      @(negedge clk);
      chk("misalign_cleared", 106, {31'h0, fetch_misalign}, 32'h0);
      chk("resume_req",       106, {31'h0, imem_req}, 32'h1);
      chk("resume_addr",      106, imem_addr, 32'h0000_0104);
      target = 32'h0000_0104;
`else
      chk("aligned_req",  101, {31'h0, imem_req}, 32'h1);
      chk("aligned_addr", 101, imem_addr, 32'h0000_0100);
      target = 32'h0000_0100;
`endif

      // first valid entry must arrive 3 cycles after the redirect cycle
      lat = 0;
      for (int k = 2; k < 10; k++) begin
         next_cycle();
         @(negedge clk);
         if (instr_valid) begin
            lat = k;
            break;
         end
      end
      chk("redir_latency", 200, 32'(lat), 32'd3);
      chk("redir_pc",      200, pc_out, target);
      chk("redir_instr",   200, instr_out, target ^ XORK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
